// File: rtl/apb_master_arbiter_if.sv
// Bundles the requester, response and APB signals of the arbiter.
// The master modport is the arbiter; the slave modport is requesters plus APB slave.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 8,
  parameter int PRDATA_WIDTH = PWDATA_WIDTH
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_write;
  logic [NUM_REQ*PADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQ*PWDATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [PRDATA_WIDTH-1:0]         rsp_rdata;
  logic                            rsp_err;
  logic [PADDR_WIDTH-1:0]          paddr;
  logic                            prwd;
  logic [PWDATA_WIDTH-1:0]         pwdata;
  logic                            psel;
  logic                            penable;
  logic [PRDATA_WIDTH-1:0]         prdata;
  logic                            pready;
  logic                            pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, prwd, pwdata, psel, penable
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, prwd, pwdata, psel, penable
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one APB master port,
// with a wait-state timeout that aborts a transfer whose slave never answers.
module apb_master_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 8,
  parameter int PRDATA_WIDTH = PWDATA_WIDTH,
  parameter int TIMEOUT      = 16
) (
  input logic pclock,
  input logic preset,
  apb_master_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [GW-1:0] last_gnt;
  logic [GW-1:0] gnt;
  logic [GW-1:0] idx;
  logic          gnt_any;
  logic [7:0]    wcnt;

  // Scan downward so the candidate closest after last_gnt is the one kept.
  always_comb begin
    gnt     = last_gnt;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_gnt) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        gnt     = idx;
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_any && !preset) bus.req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      state         <= IDLE;
      wcnt          <= '0;
      last_gnt      <= GW'(NUM_REQ - 1);
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.prwd      <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      case (state)
        IDLE: if (gnt_any) begin
          bus.paddr  <= bus.req_addr[gnt*PADDR_WIDTH +: PADDR_WIDTH];
          bus.pwdata <= bus.req_wdata[gnt*PWDATA_WIDTH +: PWDATA_WIDTH];
          bus.prwd   <= bus.req_write[gnt];
          last_gnt   <= gnt;
          wcnt       <= '0;
          bus.psel   <= 1'b1;
          state      <= SETUP;
        end
        SETUP: begin
          bus.penable <= 1'b1;
          wcnt        <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          // last_gnt still names the owner of the transfer in flight.
          if (bus.pready) begin
            bus.psel                <= 1'b0;
            bus.penable             <= 1'b0;
            bus.rsp_valid[last_gnt] <= 1'b1;
            bus.rsp_err             <= bus.pslverr;
            bus.rsp_rdata           <= bus.prwd ? '0 : bus.prdata;
            state                   <= IDLE;
          end else if (wcnt == 8'(TIMEOUT - 1)) begin
            bus.psel                <= 1'b0;
            bus.penable             <= 1'b0;
            bus.rsp_valid[last_gnt] <= 1'b1;
            bus.rsp_err             <= 1'b1;
            state                   <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench: a transaction-timeline model predicts grants, APB phases and
// responses each cycle; directed phases steer the randomness onto the key scenarios.
module tb_apb_master_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 4;

  logic pclock;
  logic preset;

  apb_master_arbiter_if #(.NUM_REQ(NR), .PADDR_WIDTH(AW), .PWDATA_WIDTH(DW)) bus ();

  apb_master_arbiter #(
    .NUM_REQ(NR), .PADDR_WIDTH(AW), .PWDATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .pclock(pclock),
    .preset(preset),
    .bus   (bus.master)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  int nchk, nerr, t;

  // requester side
  bit            pend [NR];
  bit            p_wr [NR];
  logic [AW-1:0] p_addr [NR];
  logic [DW-1:0] p_wd [NR];

  // transfer timeline: granted at g_cyc, SETUP at g_cyc+1, nacc ACCESS cycles, response after
  bit            busy, twr, terr, tto;
  int            g_cyc, nacc, owner, last, tw;
  logic [AW-1:0] taddr, lat_addr;
  logic [DW-1:0] twd, trd, lat_wd;
  bit            lat_wr;

  int            mode;   // 0: no new requests, 1: re-arm granted requester, 2: random
  int            nx_w;
  logic [DW-1:0] nx_rd;
  bit            nx_err;
  int            rst_cnt;
  bit            rst_at_access;
  bit            prev_psel, prev_pen;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, act, exp);
    end
  endtask

  task automatic arm(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a; p_wd[i] = d;
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NR; k++)
      if (pend[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic step();
    int            gnt, k;
    bit            rsp_now, do_rst, in_acc;
    logic [NR-1:0] e_rdy, e_rv;
    logic [DW-1:0] e_rd;
    bit            e_err;
    @(negedge pclock);
    rsp_now = busy && (t == g_cyc + 2 + nacc);
    if (rsp_now) busy = 1'b0;
    in_acc = busy && (t >= g_cyc + 2);
    k      = t - (g_cyc + 2);
    do_rst = (rst_cnt > 0) || (rst_at_access && in_acc);

    preset = do_rst;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = pend[i];
      bus.req_write[i]            = p_wr[i];
      bus.req_addr[i*AW +: AW]    = p_addr[i];
      bus.req_wdata[i*DW +: DW]   = p_wd[i];
    end
    // outside the answering ACCESS cycle the slave drives noise that must be ignored
    if (in_acc && k == tw) begin
      bus.pready = 1'b1; bus.prdata = trd; bus.pslverr = terr;
    end else begin
      bus.pready  = in_acc ? 1'b0 : 1'($urandom);
      bus.prdata  = DW'($urandom);
      bus.pslverr = 1'($urandom);
    end
    gnt = (!busy && !do_rst) ? rr_pick() : -1;
    #1;

    e_rdy = '0; if (gnt >= 0) e_rdy[gnt] = 1'b1;
    e_rv = '0; e_rd = '0; e_err = 1'b0;
    if (rsp_now) begin
      e_rv[owner] = 1'b1;
      e_rd  = (tto || twr) ? '0 : trd;
      e_err = tto ? 1'b1 : terr;
    end
    chk("req_ready", bus.req_ready, e_rdy);
    chk("psel",      bus.psel, busy);
    chk("penable",   bus.penable, in_acc);
    chk("paddr",     bus.paddr, lat_addr);
    chk("pwdata",    bus.pwdata, lat_wd);
    chk("prwd",      bus.prwd, lat_wr);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("rsp_rdata", bus.rsp_rdata, e_rd);
    chk("rsp_err",   bus.rsp_err, e_err);
    chk("pen_psel",  bus.penable & ~bus.psel, 1'b0);
    chk("rsp_1hot",  $onehot0(bus.rsp_valid), 1'b1);
    if (bus.penable && !prev_pen) chk("setup_first", prev_psel, 1'b1);
    prev_psel = bus.psel;
    prev_pen  = bus.penable;

    if (do_rst) begin
      busy = 1'b0; last = NR - 1;
      lat_addr = '0; lat_wd = '0; lat_wr = 1'b0;
      if (rst_cnt > 0) rst_cnt--;
      rst_at_access = 1'b0;
    end else if (gnt >= 0) begin
      busy = 1'b1; g_cyc = t; owner = gnt; last = gnt;
      twr = p_wr[gnt]; taddr = p_addr[gnt]; twd = p_wd[gnt];
      lat_addr = taddr; lat_wd = twd; lat_wr = twr;
      pend[gnt] = 1'b0;
      if (mode == 2) begin
        tw = $urandom_range(0, 5); trd = DW'($urandom); terr = 1'($urandom);
      end else begin
        tw = nx_w; trd = nx_rd; terr = nx_err;
      end
      tto  = (tw >= TO);
      nacc = tto ? TO : tw + 1;
      if (mode == 1) arm(gnt, 1'($urandom), $urandom, DW'($urandom));
    end
    if (mode == 2)
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) arm(i, 1'($urandom), $urandom, DW'($urandom));
    t++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    nchk = 0; nerr = 0; t = 0; busy = 1'b0; last = NR - 1; g_cyc = -100; nacc = 0;
    owner = 0; tw = 0; twr = 1'b0; terr = 1'b0; tto = 1'b0; trd = '0; twd = '0; taddr = '0;
    lat_addr = '0; lat_wd = '0; lat_wr = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
    end
    mode = 0; nx_w = 0; nx_rd = '0; nx_err = 1'b0; rst_at_access = 1'b0;
    prev_psel = 1'b0; prev_pen = 1'b0;
    preset = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    repeat (2) @(posedge pclock);

    rst_cnt = 2; run(3);                       // reset state

    arm(0, 1'b0, 32'h10, 8'h00);               // single read, zero wait
    nx_w = 0; nx_rd = 8'hA5; nx_err = 1'b0; run(6);

    mode = 1; arm(0, 1'b0, 32'h100, 8'h11); arm(1, 1'b1, 32'h200, 8'h22);
    run(12);                                   // back-to-back round robin
    mode = 0; run(10);

    arm(2, 1'b1, 32'hCAFE_0004, 8'h3C);        // write with 3 wait states, slave error
    nx_w = 3; nx_err = 1'b1; run(10);

    arm(1, 1'b0, 32'h44, 8'h00);               // pready stuck low
    nx_w = 1000; nx_err = 1'b0; run(10);

    mode = 1; nx_w = 2; nx_rd = 8'h5A;         // reset in the middle of ACCESS
    arm(0, 1'b0, 32'h300, 8'h33); arm(1, 1'b1, 32'h400, 8'h44);
    run(9); rst_at_access = 1'b1; run(12);
    mode = 0; rst_at_access = 1'b0; run(15);

    mode = 2; run(2000);                       // random traffic
    mode = 0; run(40);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
